// File: rtl/apb_timer_multi.sv
// Multi-channel APB timer: per-channel load register, control, sticky status and counter.
// Define TIMER_AUTORELOAD_EN to make TCR[6] reload TDR on overflow/underflow instead of wrapping.
module apb_timer_multi #(
  parameter int CNT_WIDTH = 8,
  parameter int NUM_CH    = 2
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] irq
);

  // APB: setup phase is psel & ~penable, access phase is psel & penable; pready is
  // always 1 so every access phase completes on its edge. Read data and pslverr are
  // registered on the setup edge so they are stable for the whole access phase.
  localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

  logic [1:0]  ch;
  logic [1:0]  reg_sel;
  logic        bad_ch;
  logic        setup;
  logic        wr_en;
  logic [31:0] rd_words [NUM_CH];
  logic [31:0] rd_sel;
  logic        unused;

  assign ch      = paddr[5:4];
  assign reg_sel = paddr[3:2];
  assign bad_ch  = ({30'd0, ch} >= 32'(NUM_CH));
  assign setup   = psel & ~penable;
  assign wr_en   = psel & penable & pwrite & ~bad_ch;
  assign pready  = 1'b1;
  assign unused  = ^{paddr[7:6], paddr[1:0], pwdata};

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    logic [CNT_WIDTH-1:0] tdr;
    logic [CNT_WIDTH-1:0] cnt;
    logic [6:0]           tcr;
    logic [1:0]           tsr;
    logic [3:0]           presc;
    logic                 irq_r;
    logic                 sel, wr_tdr, wr_tcr, wr_tsr, load;
    logic                 en, down, ar, tick, ovf_set, udf_set, ar_bit;
    logic [3:0]           limit;

    assign sel    = wr_en & (ch == 2'(g));
    assign wr_tdr = sel & (reg_sel == 2'd0);
    assign wr_tcr = sel & (reg_sel == 2'd1);
    assign wr_tsr = sel & (reg_sel == 2'd2);
    assign load   = wr_tcr & pwdata[7];

`ifdef TIMER_AUTORELOAD_EN
    assign ar_bit = pwdata[6];
`else
    assign ar_bit = 1'b0;
`endif

    assign en      = tcr[4];
    assign down    = tcr[5];
    assign ar      = tcr[6];
    assign limit   = 4'((5'd2 << tcr[1:0]) - 5'd1);
    assign tick    = en & (presc == limit);
    // A load in the same cycle swallows the tick, so it also suppresses the flags.
    assign ovf_set = tick & ~load & ~down & (cnt == ALL_ONES);
    assign udf_set = tick & ~load &  down & (cnt == '0);

    always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
        tdr   <= '0;
        cnt   <= '0;
        tcr   <= '0;
        tsr   <= '0;
        presc <= '0;
        irq_r <= 1'b0;
      end else begin
        if (wr_tdr) tdr <= pwdata[CNT_WIDTH-1:0];
        if (wr_tcr) tcr <= {ar_bit, pwdata[5:0]};

        if (!en || wr_tcr || tick) presc <= '0;
        else                       presc <= presc + 4'd1;

        if (load) begin
          cnt <= tdr;
        end else if (tick) begin
          if (!down) cnt <= (cnt == ALL_ONES) ? (ar ? tdr : '0) : cnt + 1'b1;
          else       cnt <= (cnt == '0) ? (ar ? tdr : ALL_ONES) : cnt - 1'b1;
        end

        tsr   <= (tsr & ~(wr_tsr ? pwdata[1:0] : 2'b00)) | {udf_set, ovf_set};
        irq_r <= (tsr[0] & tcr[2]) | (tsr[1] & tcr[3]);
      end
    end

    always_comb begin
      rd_words[g] = '0;
      case (reg_sel)
        2'd0:    rd_words[g] = 32'(tdr);
        2'd1:    rd_words[g] = {25'd0, tcr};
        2'd2:    rd_words[g] = {30'd0, tsr};
        default: rd_words[g] = 32'(cnt);
      endcase
    end

    assign irq[g] = irq_r;
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 2'(i)) rd_sel = rd_words[i];
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end else begin
      pslverr <= setup & bad_ch;
      prdata  <= (setup & ~pwrite & ~bad_ch) ? rd_sel : '0;
    end
  end

endmodule

// File: tb/tb_apb_timer_multi.sv
// Directed bench for apb_timer_multi: an 8-bit and a 16-bit instance on a shared APB bus,
// each selected by its own psel.
module tb_apb_timer_multi;

`ifdef TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        psel8 = 1'b0, psel16 = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata8, prdata16;
  logic        pready8, pready16, pslverr8, pslverr16;
  logic [1:0]  irq8, irq16;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  apb_timer_multi #(.CNT_WIDTH(8), .NUM_CH(2)) dut8 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel8), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata8), .pready(pready8),
    .pslverr(pslverr8), .irq(irq8)
  );

  apb_timer_multi #(.CNT_WIDTH(16), .NUM_CH(2)) dut16 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel16), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata16), .pready(pready16),
    .pslverr(pslverr16), .irq(irq16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at the negedge after the access edge
  task automatic apb_write(input bit d16, input logic [7:0] a, input logic [31:0] d);
    psel8 = !d16; psel16 = d16; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge pclk); @(negedge pclk);
    penable = 1'b1;
    @(posedge pclk); @(negedge pclk);
    psel8 = 1'b0; psel16 = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input bit d16, input logic [7:0] a,
                          output logic [31:0] data, output logic err);
    psel8 = !d16; psel16 = d16; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge pclk); @(negedge pclk);
    penable = 1'b1;
    data = d16 ? prdata16 : prdata8;
    err  = d16 ? pslverr16 : pslverr8;
    @(posedge pclk); @(negedge pclk);
    psel8 = 1'b0; psel16 = 1'b0; penable = 1'b0;
  endtask

  task automatic read_expect(input string tag, input bit d16, input logic [7:0] a,
                             input logic [31:0] exp);
    logic [31:0] data;
    logic        err;
    exp_q.push_back(exp);
    apb_read(d16, a, data, err);
    check(tag, data, exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] data;
    logic        err;
    int          cyc;

    // reset state
    repeat (3) @(negedge pclk);
    check("rst_pready", {31'd0, pready8}, 32'd1);
    check("rst_irq", {30'd0, irq8}, 32'd0);
    check("rst_prdata", prdata8, 32'd0);
    preset_n = 1'b1;
    @(negedge pclk);
    read_expect("rst_tcr", 1'b0, 8'h04, 32'h0);
    read_expect("rst_tcnt", 1'b0, 8'h0C, 32'h0);

    // reserved TCR bits
    apb_write(1'b0, 8'h04, 32'hFFFF_FFFF);
    read_expect("tcr_mask", 1'b0, 8'h04, AR ? 32'h7F : 32'h3F);
    read_expect("tsr_after_tcr", 1'b0, 8'h08, 32'h0);
    apb_write(1'b0, 8'h04, 32'h0);

    // 8-bit count down through underflow, /2
    apb_write(1'b0, 8'h00, 32'h02);
    apb_write(1'b0, 8'h04, 32'hB0);
    repeat (4) @(negedge pclk);
    read_expect("down_tcnt0", 1'b0, 8'h0C, 32'h00);
    read_expect("down_tcnt_wrap", 1'b0, 8'h0C, 32'hFF);
    read_expect("down_tsr_udf", 1'b0, 8'h08, 32'h2);
    check("down_irq_masked", {30'd0, irq8}, 32'd0);
    apb_write(1'b0, 8'h04, 32'h20);
    apb_write(1'b0, 8'h08, 32'h1);
    read_expect("tsr_w1_other", 1'b0, 8'h08, 32'h2);
    apb_write(1'b0, 8'h08, 32'h2);
    read_expect("tsr_w1c", 1'b0, 8'h08, 32'h0);

    // 16-bit count up through overflow, /16, irq
    apb_write(1'b1, 8'h00, 32'hFFFE);
    apb_write(1'b1, 8'h04, 32'h97);
    cyc = 40;
    for (int i = 1; i <= 40; i++) begin
      @(negedge pclk);
      if (irq16[0]) begin
        cyc = i;
        break;
      end
    end
    check("ovf_irq_latency", cyc, 32'd33);
    read_expect("ovf_tsr", 1'b1, 8'h08, 32'h1);
    read_expect("ovf_tcnt", 1'b1, 8'h0C, 32'h0);
    apb_write(1'b1, 8'h08, 32'h1);
    check("irq_hold", {30'd0, irq16}, 32'd1);
    @(negedge pclk);
    check("irq_drop", {30'd0, irq16}, 32'd0);

    // channel independence, read-only TCNT, bad channel
    apb_write(1'b0, 8'h00, 32'h33);
    apb_write(1'b0, 8'h04, 32'h80);
    apb_write(1'b0, 8'h14, 32'h90);
    read_expect("ind_ch0_a", 1'b0, 8'h0C, 32'h33);
    read_expect("ind_ch1_a", 1'b0, 8'h1C, 32'h01);
    repeat (10) @(negedge pclk);
    read_expect("ind_ch1_b", 1'b0, 8'h1C, 32'h07);
    read_expect("ind_ch0_b", 1'b0, 8'h0C, 32'h33);
    apb_read(1'b0, 8'h20, data, err);
    check("badch_err", {31'd0, err}, 32'd1);
    check("badch_data", data, 32'h0);
    apb_read(1'b0, 8'h00, data, err);
    check("goodch_err", {31'd0, err}, 32'd0);
    check("goodch_tdr", data, 32'h33);
    apb_write(1'b0, 8'h24, 32'hFF);
    read_expect("badch_nowrite", 1'b0, 8'h04, 32'h0);
    apb_write(1'b0, 8'h0C, 32'h55);
    read_expect("tcnt_ro", 1'b0, 8'h0C, 32'h33);

    // auto-reload on underflow (wraps when the feature is absent)
    apb_write(1'b0, 8'h00, 32'h10);
    apb_write(1'b0, 8'h04, 32'hF0);
    repeat (34) @(negedge pclk);
    read_expect("ar_tcnt", 1'b0, 8'h0C, AR ? 32'h10 : 32'hFF);
    read_expect("ar_tsr", 1'b0, 8'h08, 32'h2);
    read_expect("ar_tcr", 1'b0, 8'h04, AR ? 32'h70 : 32'h30);

    // reset mid-count
    preset_n = 1'b0;
    #1;
    check("mid_rst_irq", {30'd0, irq8}, 32'd0);
    check("mid_rst_pready", {31'd0, pready8}, 32'd1);
    @(negedge pclk);
    preset_n = 1'b1;
    read_expect("post_rst_tdr", 1'b0, 8'h00, 32'h0);
    read_expect("post_rst_tcr", 1'b0, 8'h04, 32'h0);
    read_expect("post_rst_tsr", 1'b0, 8'h08, 32'h0);
    read_expect("post_rst_tcnt0", 1'b0, 8'h0C, 32'h0);
    read_expect("post_rst_tcnt1", 1'b0, 8'h1C, 32'h0);
    check("post_rst_irq16", {30'd0, irq16}, 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
